led_onchip_ram_pipelined: RTL and testbench
===========================================

# led_onchip_ram_pipelined

Parametrised single-port Avalon-MM on-chip RAM for the LED control SoC. It supersedes the fixed 1024x32 on-chip memory with configurable width and depth, a selectable read latency (1 or 2), and `readdatavalid`/`waitrequest` handshaking. It also has an optional post-reset clear sweep, so LED pattern buffers start from a known value without an init file. It sits on the system interconnect as a slave next to the processor's data master.

## Interface
Parameters:
- `DATA_W`, 32: data width; must be a multiple of 8.
- `ADDR_W`, 10: word-address width; depth is DEPTH = 2**ADDR_W.
- `READ_LATENCY`, 1: 1 (unregistered array output) or 2 (extra output register). Any other value is a elaboration error.
- `INIT_CLEAR`, 1: 1 means run a clear sweep after reset; 0 means no sweep.
- `CLEAR_VALUE`, 0: DATA_W-bit word written to every location during the sweep.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `address`  in  ADDR_W  word address.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `byteenable`  in  DATA_W/8  per-byte write enable.
- `writedata`  in  DATA_W  write data.
- `clken`  in  1  global clock enable; low freezes the block.
- `reset_req`  in  1  reset-request hold; behaves exactly like `clken`=0.
- `readdata`  out  DATA_W  read data.
- `readdatavalid`  out  1  `readdata` is valid this cycle.
- `waitrequest`  out  1  request is not accepted this cycle.
- `init_done`  out  1  high once the block is in RUN.

## Operation
- Active enable: en = `clken` & ~`reset_req`.
- FSM states:
  - RESET: entered while `reset`=0.
  - CLEAR: sweep in progress.
  - RUN: normal operation.
- FSM transitions:
  - On `reset` release, go to CLEAR if `INIT_CLEAR`=1, else to RUN.
  - CLEAR writes `CLEAR_VALUE` to clear_ptr (all bytes) each enabled cycle, counting 0 to DEPTH-1.
  - After writing DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH enabled cycles.
- `waitrequest` = (state != RUN) | ~en.
- Accept conditions (evaluated only when `waitrequest`=0):
  - Write accepted: `chipselect` & `write`.
  - Read accepted: `chipselect` & `read` & ~`write`. Write has priority, so a simultaneous read/write is treated as a write only, with no `readdatavalid`.
- Write: byte lane i is updated only if `byteenable`[i]=1. `byteenable`=0 means no change.
- Read-during-write to the same address in consecutive cycles: the read in the later cycle returns the new data.
- Reads return old data only in the sense that array output is sampled at the read accept edge.
- Pipeline: a valid bit plus data per stage, advancing only when en=1. When en=0, all stages, the array and the FSM hold.
- `readdata` holds its last value between valid beats.
- `reset` low mid-sweep or mid-read:
  - Aborts the operation.
  - Pipeline valids clear; in-flight reads are discarded.
  - The sweep restarts from 0 on release.
  - Array contents are not otherwise cleared.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `init_done`=0, clear_ptr=0.
- Read accepted at enabled edge N gives `readdatavalid`=1 for one cycle after READ_LATENCY enabled edges (N+1 or N+2). Disabled cycles stretch this.
- Throughput is one read or write per enabled cycle. Back-to-back reads produce back-to-back valids.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- `init_done` rises on the same edge the FSM enters RUN. `waitrequest` falls that edge if en=1.
- After `reset` release, the first accept is possible after DEPTH cycles (INIT_CLEAR=1) or after 1 cycle (INIT_CLEAR=0).

## Structure
- Package `led_mem_pkg`:
  - state enum {ST_RESET, ST_CLEAR, ST_RUN}.
  - Allowed-latency constants.
  - A `bytes_of(DATA_W)` function.
- Sub-module `led_ram_core`: behavioural byte-enabled single-port array with a write port and a registered read address. It infers block RAM. Sweep muxing, FSM and the read pipeline stay in the top.

## Test plan
- Clear sweep: DATA_W=32, ADDR_W=4, CLEAR_VALUE=32'hA5A5A5A5. Release reset, then read all 16 words. Required: `waitrequest` is high for exactly 16 cycles, and every read returns A5A5A5A5.
- Byte enables: write 32'h11223344 with be=4'b1111 to addr 3, then 32'hFFFFFFFF with be=4'b0101. Required: a read of addr 3 returns 32'h11FF33FF.
- Latency: READ_LATENCY=2, back-to-back reads of addr 0..3. Required: four consecutive valid beats, starting 2 cycles after the first accept, in order.
- Stall: drop `clken` for 3 cycles with a read in flight (latency 2). Required: `waitrequest`=1 during the stall, and `readdatavalid` is delayed by exactly 3 cycles with correct data.
- Reset mid-sweep: assert `reset`=0 at sweep word 7 of 16. Required: on release, `init_done` rises after 16 more cycles, not 9.
- Simultaneous read+write to addr 5 with data 32'hDEADBEEF. Required: no `readdatavalid`, and a following read returns DEADBEEF.

Source files
------------

// File: rtl/led_mem_pkg.sv
// Shared definitions for the LED on-chip RAM slice.
//   mem_state_e : controller states (reset hold, clear sweep, normal run)
//   LAT_COMB    : read latency using the raw array output
//   LAT_REG     : read latency with one extra output register
//   bytes_of()  : number of byte lanes in a data word
package led_mem_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } mem_state_e;

  localparam int LAT_COMB = 1;
  localparam int LAT_REG  = 2;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/led_onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for the LED on-chip RAM.
//   address, chipselect, read, write, byteenable, writedata : master -> slave
//   readdata, readdatavalid, waitrequest                    : slave -> master
interface led_onchip_ram_pipelined_if
  import led_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0]           address;
  logic                        chipselect;
  logic                        read;
  logic                        write;
  logic [bytes_of(DATA_W)-1:0] byteenable;
  logic [DATA_W-1:0]           writedata;
  logic [DATA_W-1:0]           readdata;
  logic                        readdatavalid;
  logic                        waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/led_ram_core.sv
// Byte-enabled single-port RAM array.
//   clk  : clock
//   en   : clock enable; low freezes the array and the read address register
//   we   : write strobe, lane-masked by be
//   re   : load the read address register
//   addr : shared word address for the write and the read-address load
//   be   : per-byte write enable
//   wdata: write data
//   q    : array output at the registered read address (no output register)
module led_ram_core
  import led_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [bytes_of(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           q
);

  localparam int NB    = bytes_of(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] raddr_r;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      if (re) raddr_r <= addr;
    end
  end

  // Registered address, unregistered data: a write at one edge is seen by a
  // read accepted at the next edge.
  assign q = mem[raddr_r];

endmodule

// File: rtl/led_onchip_ram_pipelined.sv
// Parametrised single-port Avalon-MM on-chip RAM for the LED control SoC.
//   clk       : single rising-edge clock
//   reset     : synchronous, active-low reset
//   clken     : global clock enable; low freezes FSM, array and read pipeline
//   reset_req : reset-request hold; behaves exactly like clken low
//   bus       : Avalon-MM slave (address/chipselect/read/write/byteenable/
//               writedata in; readdata/readdatavalid/waitrequest out)
//   init_done : high once the controller is in normal operation
// After reset release an optional sweep writes CLEAR_VALUE to every word.
// Reads return data READ_LATENCY enabled edges after acceptance.
module led_onchip_ram_pipelined
  import led_mem_pkg::*;
#(
  parameter int                 DATA_W       = 32,
  parameter int                 ADDR_W       = 10,
  parameter int                 READ_LATENCY = 1,
  parameter int                 INIT_CLEAR   = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      reset_req,
  led_onchip_ram_pipelined_if.slave bus,
  output logic                      init_done
);

  localparam int NB = bytes_of(DATA_W);

  if (READ_LATENCY != LAT_COMB && READ_LATENCY != LAT_REG) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end

  logic              en;
  mem_state_e        state;
  logic [ADDR_W-1:0] clear_ptr;
  logic              sweeping;
  logic              wait_req;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] core_addr;
  logic [NB-1:0]     core_be;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_q;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p2;

  assign en = clken & ~reset_req;

  // The first sweep write happens on the edge that leaves RESET, so the
  // sweep occupies exactly DEPTH enabled cycles after reset release.
  assign sweeping = (INIT_CLEAR != 0) && reset &&
                    (state == ST_RESET || state == ST_CLEAR);

  assign wait_req        = (state != ST_RUN) | ~en;
  assign bus.waitrequest = wait_req;

  // Write wins over read; nothing is accepted on a reset edge.
  assign wr_acc = reset & ~wait_req & bus.chipselect & bus.write;
  assign rd_acc = reset & ~wait_req & bus.chipselect & bus.read & ~bus.write;

  // Controller: reset hold, clear sweep, run
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RESET;
      clear_ptr <= '0;
      init_done <= 1'b0;
    end else if (en) begin
      case (state)
        ST_RESET, ST_CLEAR: begin
          if (INIT_CLEAR == 0) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            clear_ptr <= clear_ptr + ADDR_W'(1);
            if (clear_ptr == '1) begin
              state     <= ST_RUN;
              init_done <= 1'b1;
            end else begin
              state <= ST_CLEAR;
            end
          end
        end
        ST_RUN: ;
        default: state <= ST_RESET;
      endcase
    end
  end

  // Sweep owns the array port while it runs
  assign core_addr  = sweeping ? clear_ptr   : bus.address;
  assign core_be    = sweeping ? '1          : bus.byteenable;
  assign core_wdata = sweeping ? CLEAR_VALUE : bus.writedata;

  led_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .en    (en),
    .we    (sweeping | wr_acc),
    .re    (rd_acc),
    .addr  (core_addr),
    .be    (core_be),
    .wdata (core_wdata),
    .q     (core_q)
  );

  // Stage p1: read address registered in the core, array output valid
  always_ff @(posedge clk) begin
    if (!reset) vld_p1 <= 1'b0;
    else if (en) vld_p1 <= rd_acc;
  end

  // Stage p2: captured array word. For latency 2 this is the output register;
  // for latency 1 it holds the last beat so readdata is stable between beats.
  always_ff @(posedge clk) begin
    if (!reset) rdata_p2 <= '0;
    else if (en && vld_p1) rdata_p2 <= core_q;
  end

  if (READ_LATENCY == LAT_REG) begin : g_lat2
    logic vld_p2;
    always_ff @(posedge clk) begin
      if (!reset) vld_p2 <= 1'b0;
      else if (en) vld_p2 <= vld_p1;
    end
    assign bus.readdata      = rdata_p2;
    assign bus.readdatavalid = vld_p2;
  end else begin : g_lat1
    assign bus.readdata      = vld_p1 ? core_q : rdata_p2;
    assign bus.readdatavalid = vld_p1;
  end

endmodule

// File: tb/tb_led_onchip_ram_pipelined.sv
// Two RAM instances (read latency 2 and 1) share one stimulus stream.
// A reference model tracks memory contents and readiness; expected read data
// goes into per-instance queues that negedge monitors pop and compare.
module tb_led_onchip_ram_pipelined;

  localparam int          DEPTH = 16;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 1;
  localparam logic [31:0] CLR   = 32'hA5A5A5A5;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        clken;
  logic        reset_req;
  logic [3:0]  address;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        init_done_a;
  logic        init_done_b;

  led_onchip_ram_pipelined_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
  led_onchip_ram_pipelined_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  assign ifa.address = address;  assign ifb.address = address;
  assign ifa.chipselect = cs;    assign ifb.chipselect = cs;
  assign ifa.read = rd;          assign ifb.read = rd;
  assign ifa.write = wr;         assign ifb.write = wr;
  assign ifa.byteenable = be;    assign ifb.byteenable = be;
  assign ifa.writedata = wd;     assign ifb.writedata = wd;

  led_onchip_ram_pipelined #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(LAT_A), .INIT_CLEAR(1), .CLEAR_VALUE(CLR)
  ) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .bus(ifa), .init_done(init_done_a)
  );

  led_onchip_ram_pipelined #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(LAT_B), .INIT_CLEAR(1), .CLEAR_VALUE(CLR)
  ) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .bus(ifb), .init_done(init_done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          en_edges = 0;
  int          sweep = 0;
  bit          ready = 0;
  bit          started = 0;
  bit          rst_last = 0;
  int          last_rd_cyc = 0;
  logic [31:0] ref_mem [DEPTH];
  exp_t        qa[$];
  exp_t        qb[$];
  int          a_beats[$];
  int          b_beats[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: readiness after DEPTH enabled cycles, memory contents,
  // and the expected response of every accepted read.
  always @(posedge clk) begin
    bit en_m;
    en_m = clken && !reset_req;
    cyc++;
    rst_last = !reset;
    if (!reset) begin
      started = 1;
      ready   = 0;
      sweep   = 0;
      qa.delete();
      qb.delete();
    end else if (en_m) begin
      en_edges++;
      if (!ready) begin
        sweep++;
        if (sweep == DEPTH) begin
          ready = 1;
          for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLR;
        end
      end else if (cs && wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[address][8*b +: 8] = wd[8*b +: 8];
      end else if (cs && rd) begin
        qa.push_back('{ref_mem[address], en_edges + LAT_A - 1});
        qb.push_back('{ref_mem[address], en_edges + LAT_B - 1});
        last_rd_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    bit   en_n;
    exp_t e;
    if (started) begin
      en_n = clken && !reset_req;
      if (rst_last) begin
        last_a = '0;
        chk("rst_valid_a", ifa.readdatavalid, 1'b0);
      end
      chk("wait_a", ifa.waitrequest, !ready || !en_n);
      chk("init_a", init_done_a, ready);
      if (ifa.readdatavalid) begin
        if (en_n) begin
          if (qa.size() == 0) begin
            chk("unexpected_valid_a", 1'b1, 1'b0);
          end else begin
            e = qa.pop_front();
            chk("rdata_a", ifa.readdata, e.data);
            chk("latency_a", en_edges, e.due);
            last_a = ifa.readdata;
            a_beats.push_back(cyc);
          end
        end
      end else begin
        chk("hold_a", ifa.readdata, last_a);
      end
    end
  end

  always @(negedge clk) begin
    bit   en_n;
    exp_t e;
    if (started) begin
      en_n = clken && !reset_req;
      if (rst_last) begin
        last_b = '0;
        chk("rst_valid_b", ifb.readdatavalid, 1'b0);
      end
      chk("wait_b", ifb.waitrequest, !ready || !en_n);
      chk("init_b", init_done_b, ready);
      if (ifb.readdatavalid) begin
        if (en_n) begin
          if (qb.size() == 0) begin
            chk("unexpected_valid_b", 1'b1, 1'b0);
          end else begin
            e = qb.pop_front();
            chk("rdata_b", ifb.readdata, e.data);
            chk("latency_b", en_edges, e.due);
            last_b = ifb.readdata;
            b_beats.push_back(cyc);
          end
        end
      end else begin
        chk("hold_b", ifb.readdata, last_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cs = 0; rd = 0; wr = 0;
    repeat (n) tick();
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 200; k++) begin
      if (ready && clken && !reset_req) break;
      tick();
    end
    if (k == 200) chk("wait_ready_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    wait_ready();
    cs = 1; wr = 1; rd = 0; address = a; wd = d; be = m;
    tick();
    cs = 0; wr = 0;
  endtask

  task automatic do_read(input logic [3:0] a);
    wait_ready();
    cs = 1; rd = 1; wr = 0; address = a;
    tick();
    cs = 0; rd = 0;
  endtask

  initial begin
    int na, nb, c0, nbeats;
    reset = 0; clken = 1; reset_req = 0;
    cs = 0; rd = 0; wr = 0; address = '0; be = '0; wd = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_readdata_a", ifa.readdata, 32'h0);
    chk("reset_valid_a", ifa.readdatavalid, 1'b0);
    chk("reset_wait_a", ifa.waitrequest, 1'b1);
    chk("reset_init_a", init_done_a, 1'b0);
    chk("reset_readdata_b", ifb.readdata, 32'h0);
    chk("reset_wait_b", ifb.waitrequest, 1'b1);
    @(posedge clk); #1;

    // Clear sweep: waitrequest high for exactly DEPTH cycles after release
    reset = 1;
    na = 0; nb = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ifa.waitrequest) na++;
      if (ifb.waitrequest) nb++;
      if (!ifa.waitrequest && !ifb.waitrequest) break;
    end
    chk("sweep_wait_cycles_a", na, DEPTH);
    chk("sweep_wait_cycles_b", nb, DEPTH);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) do_read(4'(i));
    idle(4);

    // Byte-lane merge
    do_write(4'd3, 32'h11223344, 4'b1111);
    do_write(4'd3, 32'hFFFFFFFF, 4'b0101);
    do_read(4'd3);
    idle(4);
    chk("be_merge_a", last_a, 32'h11FF33FF);
    chk("be_merge_b", last_b, 32'h11FF33FF);

    // Back-to-back reads after some writes
    for (int i = 0; i < 4; i++) do_write(4'(i), 32'h0BAD0000 + i, 4'hF);
    a_beats.delete();
    do_read(4'd0);
    c0 = last_rd_cyc;
    for (int i = 1; i < 4; i++) do_read(4'(i));
    idle(5);
    chk("b2b_count_a", a_beats.size(), 4);
    chk("b2b_first_a", a_beats[0] - c0, LAT_A - 1);
    for (int i = 1; i < 4; i++) chk("b2b_gap_a", a_beats[i] - a_beats[i-1], 1);
    chk("b2b_last_a", last_a, 32'h0BAD0003);

    // Stall three cycles with a read in flight
    a_beats.delete();
    do_read(4'd2);
    c0 = last_rd_cyc;
    clken = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wait_a", ifa.waitrequest, 1'b1);
      chk("stall_novalid_a", ifa.readdatavalid, 1'b0);
      @(posedge clk); #1;
    end
    clken = 1;
    idle(4);
    chk("stall_count_a", a_beats.size(), 1);
    chk("stall_delay_a", a_beats[0] - c0, LAT_A - 1 + 3);
    chk("stall_data_a", last_a, 32'h0BAD0002);

    // Simultaneous read + write is a write only
    a_beats.delete();
    b_beats.delete();
    wait_ready();
    cs = 1; rd = 1; wr = 1; address = 4'd5; wd = 32'hDEADBEEF; be = 4'hF;
    tick();
    idle(4);
    chk("rw_novalid_a", a_beats.size(), 0);
    chk("rw_novalid_b", b_beats.size(), 0);
    do_read(4'd5);
    idle(4);
    chk("rw_readback_a", last_a, 32'hDEADBEEF);
    chk("rw_readback_b", last_b, 32'hDEADBEEF);

    // Randomised traffic with enable and reset-request drops
    for (int i = 0; i < 400; i++) begin
      clken     = ($urandom % 10) != 0;
      reset_req = ($urandom % 20) == 0;
      cs        = ($urandom % 8) != 0;
      rd        = $urandom % 2;
      wr        = ($urandom % 3) == 0;
      address   = 4'($urandom % 16);
      be        = 4'($urandom);
      wd        = $urandom;
      tick();
    end
    clken = 1; reset_req = 0;
    idle(6);

    // Reset during a read and again mid-sweep; sweep restarts from word 0
    do_read(4'd2);
    reset = 0;
    idle(2);
    reset = 1;
    idle(7);
    reset = 0;
    idle(2);
    reset = 1;
    na = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (init_done_a) break;
      na++;
    end
    chk("midsweep_init_cycles_a", na, DEPTH);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) do_read(4'(i));
    idle(6);

    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
